// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: word load/store stage with req/ack memory handshake, misalignment and timeout faults
module lsu_mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  typedef enum logic [1:0] {IDLE, REQ, FAULT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic misal, tmo, fin;
  assign misal = addr[1:0] != 2'b00;
  assign tmo   = cnt == LAST;
  // an ack arriving in the timeout cycle wins over the timeout
  assign fin   = state == REQ && (mem_ack || tmo);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (start ? (misal ? FAULT : REQ) : IDLE)
             : (state == REQ)   ? (fin ? DONE : REQ)
             : (state == FAULT) ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else begin
      done <= state == FAULT || fin;
      if (state == IDLE && start) begin
        busy <= 1'b1;
        err  <= misal;
        if (!misal) begin
          mem_req   <= 1'b1;
          mem_we    <= is_store;
          mem_addr  <= addr[31:2];
          mem_wdata <= wdata;
          cnt       <= '0;
        end
      end
      if (state == REQ) begin
        cnt <= (cnt == '1) ? cnt : cnt + ONE;
        if (fin) begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          err     <= !mem_ack;
          if (mem_ack && !mem_we) rdata <= mem_rdata;
        end
      end
      if (state == FAULT) busy <= 1'b0;
    end
  end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store stage of the MiniRISC datapath. Takes the effective address from the ALU and runs one word-sized load or store against the data memory through a req/ack handshake. It stalls the pipeline while the access is outstanding. It holds the loaded word on `rdata`, which drives the `mem` input of the writeback select.

## Interface
- `TIMEOUT`, default 255: cycles `mem_req` may stay high without `mem_ack` before the access is aborted (range 2..65535).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request from control; sampled only in IDLE.
- `is_store` in 1: 1 = store word, 0 = load word; sampled with `start`.
- `addr` in 32: byte effective address from the ALU; sampled with `start`.
- `wdata` in 32: store data from the register file; sampled with `start`.
- `busy` out 1: pipeline stall.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: last loaded word; feeds writeback `mem`.
- `err` out 1: misaligned or timed-out access; valid with `done`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write enable.
- `mem_addr` out 30: word address, equal to `addr[31:2]`.
- `mem_wdata` out 32: store data.
- `mem_ack` in 1: memory acknowledge; ignored unless `mem_req` = 1.
- `mem_rdata` in 32: load data; valid in the `mem_ack` cycle.

## Operation
- All outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE, and the timeout counter is 0.
- FSM states: IDLE, REQ, FAULT, DONE.
- IDLE, `start` = 1 with `addr[1:0]` = 0:
  - latch `is_store`, `addr[31:2]` and `wdata` into `mem_we`, `mem_addr` and `mem_wdata`;
  - set `mem_req` = 1 and `busy` = 1, clear `err`, clear the counter;
  - go to REQ.
- IDLE, `start` = 1 with `addr[1:0]` != 0: no memory request is made; set `busy` = 1, set `err` = 1, go to FAULT.
- REQ:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until `mem_ack` is sampled high;
  - the counter increments every cycle.
- REQ, `mem_ack` = 1:
  - drop `mem_req` and `busy`, go to DONE;
  - on a load, capture `mem_rdata` into `rdata`;
  - on a store, leave `rdata` unchanged.
- REQ, no ack with counter = `TIMEOUT-1`: drop `mem_req` and `busy`, set `err` = 1, go to DONE; `rdata` is unchanged.
- A simultaneous ack and timeout count as an ack: the access completes with `err` = 0.
- FAULT: drop `busy`, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `err` holds its value until the next accepted `start`.
- `start` in REQ, FAULT or DONE is ignored and not queued; control must wait for `done`.
- `rdata` holds its value until the next successful load and is never cleared except by reset.
- Counter width is ceil(log2(`TIMEOUT`)); the counter saturates and never wraps.
- Reset mid-access drops `mem_req` immediately with no completion pulse. The memory must tolerate an abandoned request.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `busy` = `mem_req` = 1.
- Earliest ack is at cycle 1 (zero-wait memory). With ack at cycle k, `done` is at cycle k+1 and `rdata` is valid from cycle k+1 onward.
- Zero-wait access: 2 cycles from `start` to `done`.
- Misaligned access: `busy` at cycle 1, FAULT; `done` with `err` at cycle 2.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles (1..`TIMEOUT`); `done` with `err` at cycle `TIMEOUT`+1.
- Back-to-back: the earliest next `start` is the cycle after `done`, so the minimum issue interval is 3 cycles.
- `busy` is 0 in DONE, so the pipeline advances in the `done` cycle and writeback samples `rdata` then.

## Test plan
- Zero-wait load: `addr` = 0x0000_0104, `mem_ack` tied high, `mem_rdata` = 0xDEAD_BEEF.
  - Required: `mem_addr` = 0x41 and `mem_we` = 0 at cycle 1; `done` = 1 and `rdata` = 0xDEAD_BEEF at cycle 2; `err` = 0.
- Store with 3 wait states: `is_store` = 1, `addr` = 0x20, `wdata` = 0x1234_5678, ack at cycle 4.
  - Required: `mem_req` and `mem_we` high with `mem_wdata` stable for cycles 1-4; `done` at cycle 5; `rdata` unchanged.
- Misaligned load: `addr` = 0x0000_0102.
  - Required: `mem_req` never asserts; `busy` = 1 at cycle 1; `done` = 1 and `err` = 1 at cycle 2.
- Timeout: `TIMEOUT` = 4, `mem_ack` held 0.
  - Required: `mem_req` high for cycles 1-4 only; `done` = 1 and `err` = 1 at cycle 5; the next valid access clears `err`.
- `start` while busy: second `start` pulses during a 5-wait load.
  - Required: exactly one memory transaction and one `done`; latched `mem_addr` unchanged.
- Reset mid-request: assert `rst_n` = 0 at cycle 2 of a pending load.
  - Required: `mem_req`, `busy`, `done`, `err` and `rdata` all 0 asynchronously; a later `start` performs a normal access.
